pwm_capture: RTL

- PWM receiver/demodulator, the receiving end of the synth's PWM audio output.
- Recovers the 9-bit duty-cycle sample per PWM frame from a single-wire PWM input, with a 1-cycle valid strobe.
- Used for loopback self-test of the audio path: chip pwm_o is routed back to a pin, and the recovered samples are compared against the combined waveform.
- Also reports frame-alignment lock and period errors.

---
 rtl/pwm_capture_if.sv | 36 +++
 rtl/pwm_capture.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: signal bundle between a PWM capture block and its environment.
//   en           - capture enable (environment -> capture)
//   pwm_i        - raw, asynchronous PWM line (environment -> capture)
//   sample_o     - last recovered duty-cycle sample (capture -> environment)
//   valid_o      - 1-cycle strobe when sample_o updates
//   period_err_o - 1-cycle strobe on a short frame
//   locked_o     - frame alignment established
// Modports: master drives en/pwm_i and observes results; slave is the capture block.
interface pwm_capture_if #(
    parameter int unsigned WIDTH = 9
);
    logic             en;
    logic             pwm_i;
    logic [WIDTH-1:0] sample_o;
    logic             valid_o;
    logic             period_err_o;
    logic             locked_o;

    modport master (
        output en,
        output pwm_i,
        input  sample_o,
        input  valid_o,
        input  period_err_o,
        input  locked_o
    );

    modport slave (
        input  en,
        input  pwm_i,
        output sample_o,
        output valid_o,
        output period_err_o,
        output locked_o
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: PWM receiver that recovers one duty-cycle sample per PWM frame.
// A frame starts on a rising edge of the synchronised line and lasts PERIOD clocks.
// The number of high cycles in the frame, saturated to 2^WIDTH-1, is published on
// sample_o with a 1-cycle valid_o strobe. A rise arriving before PERIOD clocks is a
// short frame (period_err_o strobe, lock lost). No rise by PERIOD clocks is a timeout,
// which is reported like a normal frame so constant-level lines still produce samples.
// Ports:
//   clk   - system clock
//   n_rst - synchronous active-low reset
//   bus   - pwm_capture_if slave modport (en, pwm_i in; sample_o, valid_o,
//           period_err_o, locked_o out)
module pwm_capture #(
    parameter int unsigned WIDTH       = 9,
    parameter int unsigned PERIOD      = 512,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    pwm_capture_if.slave        bus
);
    localparam int unsigned CntW  = $clog2(PERIOD) + 1;
    localparam int unsigned GoodW = $clog2(LOCK_FRAMES + 1);

    localparam logic [CntW-1:0]  PeriodCnt = CntW'(PERIOD);
    localparam logic [CntW-1:0]  FullScale = CntW'((1 << WIDTH) - 1);
    localparam logic [GoodW-1:0] LockCnt   = GoodW'(LOCK_FRAMES);

    typedef enum logic [0:0] {StHunt, StTrack} state_e;

    state_e           state_q;
    logic             meta_q;
    logic             sync_q;
    logic             prev_q;
    logic [CntW-1:0]  len_cnt;
    logic [CntW-1:0]  hi_cnt;
    logic [GoodW-1:0] good_cnt;
    logic [WIDTH-1:0] sample_q;
    logic             valid_q;
    logic             err_q;
    logic             locked_q;

    logic             rise;
    logic             len_full;
    logic [GoodW-1:0] good_inc;
    logic [WIDTH-1:0] sample_sat;

    assign rise       = sync_q & ~prev_q;
    assign len_full   = (len_cnt == PeriodCnt);
    assign good_inc   = (good_cnt == LockCnt) ? good_cnt : good_cnt + GoodW'(1);
    // A fully-high frame counts PERIOD cycles, one more than the full-scale code.
    assign sample_sat = (hi_cnt > FullScale) ? WIDTH'(FullScale) : WIDTH'(hi_cnt);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= StHunt;
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            prev_q   <= 1'b0;
            len_cnt  <= '0;
            hi_cnt   <= '0;
            good_cnt <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            meta_q  <= bus.pwm_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (!bus.en) begin
                // Disable beats any frame event in the same cycle; sample_q is kept.
                state_q  <= StHunt;
                len_cnt  <= '0;
                hi_cnt   <= '0;
                good_cnt <= '0;
                locked_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StHunt: begin
                        if (rise) begin
                            state_q <= StTrack;
                            len_cnt <= CntW'(1);
                            hi_cnt  <= CntW'(1);
                        end
                    end
                    StTrack: begin
                        if (rise && !len_full) begin
                            // Short frame: drop lock and realign to this rise.
                            err_q    <= 1'b1;
                            good_cnt <= '0;
                            locked_q <= 1'b0;
                            len_cnt  <= CntW'(1);
                            hi_cnt   <= CntW'(1);
                        end else if (len_full) begin
                            // Normal end or timeout. This cycle is cycle 0 of the next
                            // frame; on a rise the level is 1, so both cases count it.
                            valid_q  <= 1'b1;
                            sample_q <= sample_sat;
                            good_cnt <= good_inc;
                            if (good_inc == LockCnt) begin
                                locked_q <= 1'b1;
                            end
                            len_cnt  <= CntW'(1);
                            hi_cnt   <= CntW'(sync_q);
                        end else begin
                            len_cnt <= len_cnt + CntW'(1);
                            hi_cnt  <= hi_cnt + CntW'(sync_q);
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    assign bus.sample_o     = sample_q;
    assign bus.valid_o      = valid_q;
    assign bus.period_err_o = err_q;
    assign bus.locked_o     = locked_q;
endmodule
